mem_arbiter: RTL and testbench

Single-port RAM arbiter for the CPU32 core. It shares one synchronous word-wide RAM between the instruction-fetch port and the load/store data port, and grants at most one access per cycle. Data requests win by default, and a starvation counter bounds fetch latency. For the data port it also handles byte/half-word lane placement on stores, and alignment plus sign/zero extension on loads.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU32 fetch/data ports, the arbiter and the single-port RAM.
// The slave side is the arbiter; the master side is the CPU plus the RAM.
interface mem_arbiter_if #(
    parameter int ADRS_W = 16
);
    logic              f_req;
    logic [31:0]       f_adrs;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              f_err;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_width;
    logic              d_sign;
    logic [31:0]       d_adrs;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADRS_W-1:0] ram_adrs;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  f_req, f_adrs,
        input  d_req, d_we, d_width, d_sign, d_adrs, d_wdata,
        input  ram_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output ram_en, ram_we, ram_be, ram_adrs, ram_wdata
    );

    modport master (
        output f_req, f_adrs,
        output d_req, d_we, d_width, d_sign, d_adrs, d_wdata,
        output ram_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  ram_en, ram_we, ram_be, ram_adrs, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for CPU32: data port wins by default, fetch is promoted
// after MAX_WAIT lost cycles. Handles store lane placement and load extraction.
module mem_arbiter #(
    parameter int ADRS_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk_cpu,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    localparam logic [1:0] W_WORD   = 2'b00;
    localparam logic [1:0] W_HALF   = 2'b01;
    localparam logic [1:0] W_BYTE   = 2'b10;

    logic [3:0] wait_q,     wait_d;
    logic       f_rvalid_q, f_rvalid_d;
    logic       f_err_q,    f_err_d;
    logic       d_rvalid_q, d_rvalid_d;
    logic       d_err_q,    d_err_d;
    logic       d_store_q,  d_store_d;
    logic [1:0] ld_width_q, ld_width_d;
    logic       ld_sign_q,  ld_sign_d;
    logic [1:0] ld_off_q,   ld_off_d;

    logic        f_mis;
    logic        d_mis;
    logic        f_win;
    logic        d_win;
    logic [1:0]  d_off;
    logic [3:0]  d_lanes;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    logic unused_adrs_bits;
    assign unused_adrs_bits = ^{bus.f_adrs[31:ADRS_W+2], bus.d_adrs[31:ADRS_W+2]};

    always_comb begin
        d_off = bus.d_adrs[1:0];
        f_mis = |bus.f_adrs[1:0];
        d_mis   = 1'b1;
        d_lanes = 4'b0000;
        case (bus.d_width)
            W_WORD: begin
                d_mis   = |d_off;
                d_lanes = 4'b1111;
            end
            W_HALF: begin
                d_mis   = d_off[0];
                d_lanes = 4'b0011 << d_off;
            end
            W_BYTE: begin
                d_mis   = 1'b0;
                d_lanes = 4'b0001 << d_off;
            end
            default: begin
                d_mis   = 1'b1;
                d_lanes = 4'b0000;
            end
        endcase
    end

    // Grants are combinational but forced low while reset is asserted.
    always_comb begin
        f_win     = bus.f_req && (!bus.d_req || (wait_q == WAIT_MAX));
        d_win     = bus.d_req && !f_win;
        bus.f_gnt = reset_n && f_win;
        bus.d_gnt = reset_n && d_win;
    end

    // A misaligned grant still consumes the slot but never touches the RAM.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_be    = 4'b0000;
        bus.ram_adrs  = '0;
        bus.ram_wdata = '0;
        if (bus.d_gnt) begin
            bus.ram_adrs = bus.d_adrs[ADRS_W+1:2];
            if (!d_mis) begin
                bus.ram_en = 1'b1;
                bus.ram_we = bus.d_we;
                bus.ram_be = d_lanes;
                if (bus.d_we) begin
                    bus.ram_wdata = bus.d_wdata << {d_off, 3'b000};
                end
            end
        end else if (bus.f_gnt) begin
            bus.ram_adrs = bus.f_adrs[ADRS_W+1:2];
            if (!f_mis) begin
                bus.ram_en = 1'b1;
                bus.ram_be = 4'b1111;
            end
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!bus.f_req || bus.f_gnt) begin
            wait_d = 4'd0;
        end else if (wait_q < WAIT_MAX) begin
            wait_d = wait_q + 4'd1;
        end

        f_rvalid_d = bus.f_gnt;
        f_err_d    = bus.f_gnt && f_mis;
        d_rvalid_d = bus.d_gnt;
        d_err_d    = bus.d_gnt && d_mis;
        d_store_d  = bus.d_gnt && bus.d_we;

        ld_width_d = ld_width_q;
        ld_sign_d  = ld_sign_q;
        ld_off_d   = ld_off_q;
        if (bus.d_gnt) begin
            ld_width_d = bus.d_width;
            ld_sign_d  = bus.d_sign;
            ld_off_d   = d_off;
        end
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            wait_q     <= 4'd0;
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_store_q  <= 1'b0;
            ld_width_q <= W_WORD;
            ld_sign_q  <= 1'b0;
            ld_off_q   <= 2'b00;
        end else begin
            wait_q     <= wait_d;
            f_rvalid_q <= f_rvalid_d;
            f_err_q    <= f_err_d;
            d_rvalid_q <= d_rvalid_d;
            d_err_q    <= d_err_d;
            d_store_q  <= d_store_d;
            ld_width_q <= ld_width_d;
            ld_sign_q  <= ld_sign_d;
            ld_off_q   <= ld_off_d;
        end
    end

    // RAM data arrives the cycle after the grant, so extraction uses the captured attributes.
    always_comb begin
        ld_shift = bus.ram_rdata >> {ld_off_q, 3'b000};
        case (ld_width_q)
            W_HALF:  ld_data = {{16{ld_sign_q & ld_shift[15]}}, ld_shift[15:0]};
            W_BYTE:  ld_data = {{24{ld_sign_q & ld_shift[7]}}, ld_shift[7:0]};
            default: ld_data = ld_shift;
        endcase

        bus.f_rvalid = f_rvalid_q;
        bus.f_err    = f_err_q;
        bus.f_rdata  = (f_rvalid_q && !f_err_q) ? bus.ram_rdata : 32'd0;

        bus.d_rvalid = d_rvalid_q;
        bus.d_err    = d_err_q;
        bus.d_rdata  = (d_rvalid_q && !d_err_q && !d_store_q) ? ld_data : 32'd0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared against a byte-addressed memory model and a lost-cycle arbitration model.
module tb_mem_arbiter;
    localparam int MAX_WAIT = 4;

    logic clk_cpu;
    logic reset_n;

    mem_arbiter_if #(.ADRS_W(16)) bus ();

    mem_arbiter #(.ADRS_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_cpu (clk_cpu),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    logic [31:0] ram_mem [0:15];
    logic [7:0]  bmem    [0:63];

    // Word-wide synchronous RAM the arbiter talks to.
    always @(posedge clk_cpu) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.ram_be[i]) ram_mem[bus.ram_adrs[3:0]][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
                end
            end else begin
                bus.ram_rdata <= ram_mem[bus.ram_adrs[3:0]];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    logic        f_pend = 1'b0;
    logic [31:0] fa     = '0;
    logic        d_pend = 1'b0;
    logic        dwe    = 1'b0;
    logic [1:0]  dw     = 2'b00;
    logic        ds     = 1'b0;
    logic [31:0] da     = '0;
    logic [31:0] dwd    = '0;
    int          losses = 0;

    bit          exp_fv = 0, exp_fe = 0, exp_dv = 0, exp_de = 0;
    logic [31:0] exp_fd = '0, exp_dd = '0;
    bit          g_f, g_d;

    function automatic logic [31:0] mem_read(input int a, input int n, input bit s);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = bmem[a+k];
        if (s && n < 4 && v[8*n-1]) begin
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic post_f(input logic [31:0] a);
        if (!f_pend) begin
            f_pend = 1'b1;
            fa     = a;
        end
    endtask

    task automatic post_d(input bit we, input logic [1:0] w, input bit s,
                          input logic [31:0] a, input logic [31:0] wd);
        if (!d_pend) begin
            d_pend = 1'b1;
            dwe = we; dw = w; ds = s; da = a; dwd = wd;
        end
    endtask

    // One clock cycle: drive pending requests, check last cycle's responses,
    // check this cycle's grant and RAM access, and predict next cycle's responses.
    task automatic step(input bit skip_edge);
        bit fm, dm, want_f, want_d;
        int n, lane;
        logic [3:0]  ebe;
        logic [31:0] ewd, msk;
        if (!skip_edge) @(negedge clk_cpu);
        bus.f_req   = f_pend;
        bus.f_adrs  = fa;
        bus.d_req   = d_pend;
        bus.d_we    = dwe;
        bus.d_width = dw;
        bus.d_sign  = ds;
        bus.d_adrs  = da;
        bus.d_wdata = dwd;
        #1;
        chk("f_rvalid", bus.f_rvalid, exp_fv);
        if (exp_fv) begin
            chk("f_err", bus.f_err, exp_fe);
            chk("f_rdata", bus.f_rdata, exp_fd);
        end
        chk("d_rvalid", bus.d_rvalid, exp_dv);
        if (exp_dv) begin
            chk("d_err", bus.d_err, exp_de);
            chk("d_rdata", bus.d_rdata, exp_dd);
        end

        want_f = f_pend && (!d_pend || losses >= MAX_WAIT);
        want_d = d_pend && !want_f;
        g_f = bus.f_gnt;
        g_d = bus.d_gnt;
        chk("f_gnt", g_f, want_f);
        chk("d_gnt", g_d, want_d);

        fm = (fa[1:0] != 2'b00);
        n  = (dw == 2'b00) ? 4 : (dw == 2'b01) ? 2 : 1;
        dm = (dw == 2'b11) || ((int'(da) % n) != 0);

        exp_fv = want_f;
        exp_dv = want_d;
        exp_fe = want_f && fm;
        exp_de = want_d && dm;
        exp_fd = '0;
        exp_dd = '0;
        chk("ram_en", bus.ram_en, (want_f && !fm) || (want_d && !dm));
        if (want_f && !fm) begin
            exp_fd = mem_read(int'(fa), 4, 1'b0);
            chk("ram_we_f", bus.ram_we, 1'b0);
            chk("ram_adrs_f", bus.ram_adrs, fa >> 2);
        end
        if (want_d && !dm) begin
            chk("ram_we_d", bus.ram_we, dwe);
            chk("ram_adrs_d", bus.ram_adrs, da >> 2);
            if (dwe) begin
                ebe = '0; ewd = '0; msk = '0;
                for (int k = 0; k < n; k++) begin
                    lane = (int'(da) + k) % 4;
                    ebe[lane]          = 1'b1;
                    ewd[8*lane +: 8]   = dwd[8*k +: 8];
                    msk[8*lane +: 8]   = 8'hFF;
                    bmem[int'(da) + k] = dwd[8*k +: 8];
                end
                chk("ram_be", bus.ram_be, ebe);
                chk("ram_wdata", bus.ram_wdata & msk, ewd);
            end else begin
                exp_dd = mem_read(int'(da), n, ds);
            end
        end

        losses = (f_pend && !want_f) ? ((losses < MAX_WAIT) ? losses + 1 : losses) : 0;
        if (want_f) f_pend = 1'b0;
        if (want_d) d_pend = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            ram_mem[i] = w;
            for (int k = 0; k < 4; k++) bmem[4*i+k] = w[8*k +: 8];
        end
        bus.ram_rdata = '0;

        // Reset held with both ports requesting.
        reset_n = 1'b0;
        bus.f_req = 1'b1; bus.f_adrs = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_width = 2'b00; bus.d_sign = 1'b0;
        bus.d_adrs = 32'h4; bus.d_wdata = '0;
        repeat (2) @(negedge clk_cpu);
        #1;
        chk("rst_f_gnt", bus.f_gnt, 1'b0);
        chk("rst_d_gnt", bus.d_gnt, 1'b0);
        chk("rst_ram_en", bus.ram_en, 1'b0);
        chk("rst_ram_we", bus.ram_we, 1'b0);
        chk("rst_f_rvalid", bus.f_rvalid, 1'b0);
        chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
        chk("rst_f_rdata", bus.f_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        reset_n = 1'b1;
        post_f(32'h10);
        post_d(1'b0, 2'b00, 1'b0, 32'h4, 32'd0);
        step(1'b1);
        chk("rst_first_dgnt", g_d, 1'b1);
        step(1'b0);
        step(1'b0);

        // Starvation bound with data held continuously.
        post_f(32'h20);
        for (int i = 0; i < 6; i++) begin
            post_d(1'b0, 2'b00, 1'b0, 32'(4 * i), 32'd0);
            step(1'b0);
            chk("starve_f_gnt", g_f, i == 4);
            chk("starve_d_gnt", g_d, i != 4);
        end
        step(1'b0);

        // Byte store / load round trip.
        post_d(1'b1, 2'b10, 1'b0, 32'h6, 32'h0000_00A5);
        step(1'b0);
        chk("sb_be", bus.ram_be, 4'b0100);
        chk("sb_wdata", bus.ram_wdata, 32'h00A5_0000);
        post_d(1'b0, 2'b10, 1'b1, 32'h6, 32'd0);
        step(1'b0);
        post_d(1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
        step(1'b0);
        chk("lb_rdata", bus.d_rdata, 32'hFFFF_FFA5);
        step(1'b0);
        chk("lbu_rdata", bus.d_rdata, 32'h0000_00A5);

        // Half-word loads with and without sign extension.
        post_d(1'b1, 2'b00, 1'b0, 32'h0, 32'h8001_7FFF);
        step(1'b0);
        post_d(1'b0, 2'b01, 1'b1, 32'h2, 32'd0);
        step(1'b0);
        post_d(1'b0, 2'b01, 1'b0, 32'h0, 32'd0);
        step(1'b0);
        chk("lh_rdata", bus.d_rdata, 32'hFFFF_8001);
        step(1'b0);
        chk("lhu_rdata", bus.d_rdata, 32'h0000_7FFF);

        // Misaligned data and fetch accesses.
        post_d(1'b0, 2'b00, 1'b0, 32'h2, 32'd0);
        step(1'b0);
        chk("mis_lw_gnt", g_d, 1'b1);
        chk("mis_lw_en", bus.ram_en, 1'b0);
        post_f(32'h1);
        step(1'b0);
        chk("mis_lw_err", bus.d_err, 1'b1);
        chk("mis_lw_rdata", bus.d_rdata, 32'd0);
        chk("mis_f_gnt", g_f, 1'b1);
        chk("mis_f_en", bus.ram_en, 1'b0);
        step(1'b0);
        chk("mis_f_err", bus.f_err, 1'b1);
        chk("mis_f_rdata", bus.f_rdata, 32'd0);
        post_d(1'b0, 2'b11, 1'b0, 32'h8, 32'd0);
        step(1'b0);
        chk("rsvd_en", bus.ram_en, 1'b0);
        step(1'b0);
        chk("rsvd_err", bus.d_err, 1'b1);

        // Reset between a grant and its response.
        post_d(1'b0, 2'b00, 1'b0, 32'h8, 32'd0);
        step(1'b0);
        chk("rstmid_gnt", g_d, 1'b1);
        #1 reset_n = 1'b0;
        @(negedge clk_cpu);
        #1;
        chk("rstmid_d_rvalid", bus.d_rvalid, 1'b0);
        exp_fv = 0; exp_dv = 0; losses = 0;
        f_pend = 1'b0; d_pend = 1'b0;
        reset_n = 1'b1;
        step(1'b1);
        step(1'b0);

        // Random mixed traffic.
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 7) == 0)
                    post_f(32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3)));
                else
                    post_f(32'($urandom_range(0, 15) * 4));
            end
            if ($urandom_range(0, 2) != 0) begin
                post_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       32'($urandom_range(0, 63)), $urandom);
            end
            step(1'b0);
        end
        f_pend = 1'b0;
        d_pend = 1'b0;
        step(1'b0);
        step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
